mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus (mem_a / mem_wr / CPU data out / mem_din).
- Provides a 128 KB RAM with 1-cycle read latency and the memory-mapped I/O window at 0x30000–0x30007:
  - UART receive and transmit byte queues.
  - Cycle counter.
  - Program-stop flag.
- Sits between the cpu top and the board-level UART/testbench, replacing the hardware RAM/IO controller in simulation.

Parameters:
- ADDR_WIDTH, 17, RAM address bits (2^17 bytes = 128 KB).
- TX_DEPTH, 8, transmit queue entries (power of two, >=4).
- INIT_FILE, "", hex image loaded into RAM at elaboration; empty means no load.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  when low, bus is ignored: no RAM/IO side effects, mem_din holds
- mem_a  input  32  byte address from CPU; only bits 17:0 decoded
- mem_wr  input  1  1 = write, 0 = read
- mem_dout  input  8  write data from CPU
- mem_din  output  8  read data to CPU, valid the cycle after the address
- io_buffer_full  output  1  registered; tells CPU to stop writing 0x30000
- rx_data  input  8  UART receive byte
- rx_valid  input  1  rx_data valid; accepted when rx_ready
- rx_ready  output  1  responder can accept an rx byte
- tx_data  output  8  head of transmit queue
- tx_valid  output  1  transmit queue non-empty
- tx_ready  input  1  consumer takes tx_data this cycle when tx_valid
- prog_stop  output  1  sticky; set by a write to 0x30004

Behaviour:
- Reset values:
  - mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, prog_stop=0, rx_ready=1.
  - Counter and snapshot cleared; both queues empty.
  - RAM contents are not reset.
- Decode:
  - io = mem_a[17:16]==2'b11.
  - RAM = mem_a[17]==0.
  - Other addresses (0x20000–0x2FFFF): reads return 0x00, writes dropped.
- Read, rdy_in=1, mem_wr=0: mem_din at cycle N+1 reflects the address presented at cycle N.
  - RAM: the byte at mem_a[ADDR_WIDTH-1:0].
  - 0x30000: pop the rx byte. If the rx holding register is empty, return 0x00 and do not pop.
  - 0x30004: return counter[7:0] and latch the full counter into the snapshot register in the same cycle.
  - 0x30005 / 0x30006 / 0x30007: return snapshot[15:8] / [23:16] / [31:24].
- Write, rdy_in=1, mem_wr=1:
  - RAM: the byte is written at the clock edge. A read of the same address next cycle returns the new data.
  - 0x30000: enqueue mem_dout unless it is 0x00. If the queue is full, the byte is dropped.
  - 0x30004: set prog_stop and enqueue 0x00. The enqueue happens even though 0x00 is normally ignored. If the queue is full, the 0x00 is dropped but prog_stop is still set.
  - mem_din is unchanged after a write cycle.
- rdy_in=0: mem_din, RAM, queues, snapshot and prog_stop hold. The counter still increments. The tx queue still drains to tx_ready. The rx register still loads.
- Counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF→0.
- Rx: single holding register.
  - rx_ready = empty.
  - Load on rx_valid && rx_ready.
  - A simultaneous pop and load in the same cycle is impossible because rx_ready=0 when full.
- Tx queue: circular buffer, pointers one bit wider than log2(TX_DEPTH) for full/empty.
  - A simultaneous enqueue and dequeue keeps the count.
  - An enqueue while full is dropped even if a dequeue happens in the same cycle.
- io_buffer_full registered: 1 when next count >= TX_DEPTH-2. This gives margin for CPU pipeline writes already in flight.
- prog_stop is cleared only by reset.

Optional Feature:
- MEM_IO_TX_FIFO_EN defined: tx path is the TX_DEPTH queue above.
- Undefined: tx path is a single holding register.
  - io_buffer_full = register occupied.
  - Writes while occupied are dropped.
  - TX_DEPTH is ignored.

Decomposition:
- Shared package:
  - IO_BASE 0x30000, IO_UART_OFS 0, IO_CLK_OFS 4.
  - RAM_LIMIT 0x20000.
  - Byte/word width constants.
- Natural sub-module: io_tx_fifo, parameterised depth, push/pop/count/full/empty. It is instantiated only under MEM_IO_TX_FIFO_EN.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address; reading 0x20004 -> mem_din=0x00.
- Writes 'H'(0x48), 0x00, 'i'(0x69) to 0x30000 with tx_ready=1 -> tx stream 0x48, 0x69 only.
- After 100 cycles from reset, read 0x30004 then 0x30005–0x30007 -> bytes reassemble to the counter value at the 0x30004 cycle (0x64 when read at cycle 100), unchanged by later counting.
- rx_valid with 0x37, then read 0x30000 twice -> 0x37 then 0x00; rx_ready returns to 1 after the first read.
- tx_ready=0, write 8 non-zero bytes (TX_DEPTH=8) -> io_buffer_full rises after the 6th; the 9th write is dropped; releasing tx_ready drains exactly 8 bytes.
- Write to 0x30004 with rdy_in=0 -> no effect; repeat with rdy_in=1 -> prog_stop=1 next cycle and 0x00 emitted on tx; rst_in mid-drain -> queue empty, prog_stop=0.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder_pkg
// Purpose  : Shared address map, widths and region decode for mem_io_responder.
// Revision : 1.0
// ============================================================================
package mem_io_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int DEC_W  = 18;

    localparam logic [DEC_W-1:0] IO_BASE     = 18'h30000;
    localparam logic [DEC_W-1:0] RAM_LIMIT   = 18'h20000;
    localparam logic [2:0]       IO_UART_OFS = 3'd0;
    localparam logic [2:0]       IO_CLK_OFS  = 3'd4;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

    function automatic region_e decode_region(input logic [DEC_W-1:0] addr);
        if (addr < RAM_LIMIT)
            return REGION_RAM;
        if (addr[DEC_W-1:DEC_W-2] == IO_BASE[DEC_W-1:DEC_W-2])
            return REGION_IO;
        return REGION_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder_tx_fifo  (io_tx_fifo)
// Purpose  : Circular transmit byte queue; pointers carry one extra wrap bit.
// Revision : 1.0
// ============================================================================
module mem_io_responder_tx_fifo #(
    parameter  int DEPTH   = 8,
    parameter  int WIDTH   = 8,
    localparam int c_aw    = $clog2(DEPTH),
    localparam int c_cnt_w = c_aw + 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic [c_cnt_w-1:0] count,
    output logic               full,
    output logic               empty
);
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_cnt_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_rd_ptr;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == c_cnt_w'(DEPTH));
    assign empty     = (r_wr_ptr == r_rd_ptr);
    // A full queue refuses a push even when a pop frees a slot this cycle
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign head      = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Purpose  : CPU byte-bus responder: 128 KB RAM plus UART/counter/stop I/O.
//            Define MEM_IO_TX_FIFO_EN for a TX_DEPTH transmit queue,
//            otherwise a single transmit holding register is used.
// Revision : 1.0
// ============================================================================
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH = 17,
    parameter int    TX_DEPTH   = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [WORD_W-1:0] mem_a,
    input  logic              mem_wr,
    input  logic [BYTE_W-1:0] mem_dout,
    output logic [BYTE_W-1:0] mem_din,
    output logic              io_buffer_full,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              prog_stop
);
    region_e               w_region;
    logic                  w_io_hit, w_sel_uart, w_sel_clk;
    logic                  w_rd_en, w_wr_en;
    logic                  w_tx_push, w_rx_pop, w_rx_load;
    logic [BYTE_W-1:0]     w_tx_push_data, w_io_rdata;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_unused_addr;
    logic                  w_unused_init;

    logic [BYTE_W-1:0]     r_ram [0:(1<<ADDR_WIDTH)-1];
    logic [BYTE_W-1:0]     r_ram_q, r_io_q, r_rx_data;
    logic                  r_sel_ram, r_rx_full, r_stop;
    logic [WORD_W-1:0]     r_cnt;
    logic [WORD_W-9:0]     r_snap;

    assign w_region      = decode_region(mem_a[DEC_W-1:0]);
    assign w_io_hit      = (w_region == REGION_IO) && (mem_a[15:3] == IO_BASE[15:3]);
    assign w_sel_uart    = w_io_hit && (mem_a[2:0] == IO_UART_OFS);
    assign w_sel_clk     = w_io_hit && (mem_a[2:0] == IO_CLK_OFS);
    assign w_rd_en       = rdy_in && !mem_wr;
    assign w_wr_en       = rdy_in && mem_wr;
    assign w_ram_addr    = mem_a[ADDR_WIDTH-1:0];
    assign w_unused_addr = ^mem_a[WORD_W-1:DEC_W];
    assign w_unused_init = (INIT_FILE != "");

    assign w_rx_load = rx_valid && !r_rx_full;
    assign w_rx_pop  = w_rd_en && w_sel_uart && r_rx_full;
    assign rx_ready  = !r_rx_full;

    // The stop write injects a 0x00 marker that ordinary UART writes never queue
    assign w_tx_push      = w_wr_en && ((w_sel_uart && mem_dout != '0) || w_sel_clk);
    assign w_tx_push_data = w_sel_clk ? '0 : mem_dout;

    assign mem_din   = r_sel_ram ? r_ram_q : r_io_q;
    assign prog_stop = r_stop;

    always_ff @(posedge clk_in) begin
        if (w_wr_en && w_region == REGION_RAM)
            r_ram[w_ram_addr] <= mem_dout;
        if (w_rd_en && w_region == REGION_RAM)
            r_ram_q <= r_ram[w_ram_addr];
    end

    always_comb begin
        w_io_rdata = '0;
        if (w_io_hit) begin
            case (mem_a[2:0])
                IO_UART_OFS: w_io_rdata = r_rx_full ? r_rx_data : '0;
                IO_CLK_OFS:  w_io_rdata = r_cnt[7:0];
                3'd5:        w_io_rdata = r_snap[7:0];
                3'd6:        w_io_rdata = r_snap[15:8];
                3'd7:        w_io_rdata = r_snap[23:16];
                default:     w_io_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_ram <= 1'b0;
            r_io_q    <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
            r_stop    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_rx_load) begin
                r_rx_full <= 1'b1;
                r_rx_data <= rx_data;
            end else if (w_rx_pop) begin
                r_rx_full <= 1'b0;
            end
            if (w_rd_en) begin
                r_sel_ram <= (w_region == REGION_RAM);
                r_io_q    <= w_io_rdata;
                if (w_sel_clk)
                    r_snap <= r_cnt[WORD_W-1:8];
            end
            if (w_wr_en && w_sel_clk)
                r_stop <= 1'b1;
        end
    end

`ifdef MEM_IO_TX_FIFO_EN
    localparam int c_cnt_w = $clog2(TX_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_thresh = c_cnt_w'(TX_DEPTH - 2);

    logic [c_cnt_w-1:0] w_tx_count, w_tx_count_next;
    logic               w_tx_full, w_tx_empty, w_push_ok, w_pop_ok;
    logic               r_buf_full;

    mem_io_responder_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (w_tx_push),
        .push_data (w_tx_push_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    assign w_push_ok       = w_tx_push && !w_tx_full;
    assign w_pop_ok        = tx_ready && !w_tx_empty;
    assign w_tx_count_next = w_tx_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);

    // Raised two entries early so writes already in the CPU pipeline still fit
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_buf_full <= 1'b0;
        else
            r_buf_full <= (w_tx_count_next >= c_full_thresh);
    end

    assign io_buffer_full = r_buf_full;
    assign tx_valid       = !w_tx_empty;
`else
    logic              r_tx_full;
    logic [BYTE_W-1:0] r_tx_data;
    logic              w_unused_depth;

    assign w_unused_depth = (TX_DEPTH != 0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_full <= 1'b0;
            r_tx_data <= '0;
        end else if (r_tx_full) begin
            if (tx_ready)
                r_tx_full <= 1'b0;
        end else if (w_tx_push) begin
            r_tx_full <= 1'b1;
            r_tx_data <= w_tx_push_data;
        end
    end

    assign io_buffer_full = r_tx_full;
    assign tx_valid       = r_tx_full;
    assign tx_data        = r_tx_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Purpose  : Directed self-checking bench for mem_io_responder.
// Revision : 1.0
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prog_stop;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  tx_log[$];
    logic [31:0] tb_cyc;

    mem_io_responder u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .prog_stop      (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rst_in)
            tb_cyc <= 32'd0;
        else
            tb_cyc <= tb_cyc + 32'd1;
        if (!rst_in && tx_valid && tx_ready)
            tx_log.push_back(tx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] log_at(input int idx);
        if (idx < tx_log.size())
            return tx_log[idx];
        return 8'hEE;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        rdy_in = 1'b1; mem_wr = 1'b1; mem_a = a; mem_dout = d;
        @(negedge clk_in);
        rdy_in = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
        rdy_in = 1'b1; mem_wr = 1'b0; mem_a = a;
        @(negedge clk_in);
        d = mem_din;
        rdy_in = 1'b0;
    endtask

    initial begin
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_cnt;

        rst_in = 1'b1; rdy_in = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_dout = '0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("rst_mem_din", mem_din, 0);
        check_eq("rst_buf_full", io_buffer_full, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_prog_stop", prog_stop, 0);
        check_eq("rst_rx_ready", rx_ready, 1);

        // Counter snapshot at cycle 100 after reset release
        rst_in = 1'b0;
        repeat (100) @(negedge clk_in);
        bus_read(32'h30004, b0);
        check_eq("cnt_lo_at_100", b0, 8'h64);
        repeat (20) @(negedge clk_in);
        bus_read(32'h30005, b1);
        bus_read(32'h30006, b2);
        bus_read(32'h30007, b3);
        check_eq("snap_b1", b1, 0);
        check_eq("snap_b3", b3, 0);
        check_eq("snap_whole", {b3, b2, b1, b0}, 32'd100);

        // RAM and unmapped region
        bus_write(32'h00010, 8'hA5);
        bus_read(32'h00010, b0);
        check_eq("ram_raw", b0, 8'hA5);
        bus_write(32'h1FFFF, 8'h3C);
        bus_read(32'h1FFFF, b0);
        check_eq("ram_top", b0, 8'h3C);
        bus_read(32'h20004, b0);
        check_eq("unmapped_rd", b0, 0);
        bus_write(32'h20004, 8'h77);
        bus_read(32'h20004, b0);
        check_eq("unmapped_wr", b0, 0);
        bus_read(32'h00010, b0);
        bus_write(32'h00011, 8'h5A);
        check_eq("din_hold_wr", mem_din, 8'hA5);
        rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h00010; mem_dout = 8'hFF;
        @(negedge clk_in);
        mem_wr = 1'b0; mem_a = 32'h00011;
        @(negedge clk_in);
        check_eq("din_hold_nrdy", mem_din, 8'hA5);
        bus_read(32'h00010, b0);
        check_eq("ram_nrdy_wr", b0, 8'hA5);
        bus_read(32'h00011, b0);
        check_eq("ram_second", b0, 8'h5A);

        // Transmit skips 0x00 UART writes
        tx_ready = 1'b1; tx_log.delete();
        bus_write(32'h30000, 8'h48);
        bus_write(32'h30000, 8'h00);
        bus_write(32'h30000, 8'h69);
        repeat (5) @(negedge clk_in);
        check_eq("tx_hi_count", tx_log.size(), 2);
        check_eq("tx_hi_0", log_at(0), 8'h48);
        check_eq("tx_hi_1", log_at(1), 8'h69);

        // Receive holding register
        rx_valid = 1'b1; rx_data = 8'h37;
        @(negedge clk_in);
        rx_valid = 1'b0;
        check_eq("rx_ready_full", rx_ready, 0);
        bus_read(32'h30000, b0);
        check_eq("rx_pop", b0, 8'h37);
        check_eq("rx_ready_back", rx_ready, 1);
        bus_read(32'h30000, b0);
        check_eq("rx_empty_rd", b0, 0);

        // Back-pressure and fill
        tx_ready = 1'b0; tx_log.delete();
`ifdef MEM_IO_TX_FIFO_EN
        for (int i = 1; i <= 9; i++) begin
            bus_write(32'h30000, 8'(i * 8'h11));
            if (i == 5) check_eq("full_after5", io_buffer_full, 0);
            if (i == 6) check_eq("full_after6", io_buffer_full, 1);
        end
        check_eq("fill_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        repeat (12) @(negedge clk_in);
        check_eq("drain_count", tx_log.size(), 8);
        check_eq("drain_first", log_at(0), 8'h11);
        check_eq("drain_last", log_at(7), 8'h88);
`else
        bus_write(32'h30000, 8'h11);
        check_eq("full_after1", io_buffer_full, 1);
        bus_write(32'h30000, 8'h22);
        check_eq("fill_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        repeat (4) @(negedge clk_in);
        check_eq("drain_count", tx_log.size(), 1);
        check_eq("drain_first", log_at(0), 8'h11);
`endif
        check_eq("drained_full", io_buffer_full, 0);

        // Program stop
        tx_log.delete();
        rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h30004; mem_dout = 8'h00;
        @(negedge clk_in);
        mem_wr = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("stop_nrdy", prog_stop, 0);
        check_eq("stop_nrdy_tx", tx_log.size(), 0);
        bus_write(32'h30004, 8'h00);
        check_eq("stop_set", prog_stop, 1);
        repeat (3) @(negedge clk_in);
        check_eq("stop_tx_count", tx_log.size(), 1);
        check_eq("stop_tx_byte", log_at(0), 8'h00);

        // Reset while transmit data is pending
        tx_ready = 1'b0;
        bus_write(32'h30000, 8'h41);
        bus_write(32'h30000, 8'h42);
        bus_write(32'h30000, 8'h43);
        check_eq("pend_valid", tx_valid, 1);
        check_eq("stop_sticky", prog_stop, 1);
        tx_log.delete();
        tx_ready = 1'b1; rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_eq("rst2_tx_valid", tx_valid, 0);
        check_eq("rst2_prog_stop", prog_stop, 0);
        repeat (4) @(negedge clk_in);
        check_eq("rst2_no_tx", tx_log.size(), 0);

        // Snapshot with a non-zero second byte, checked after further counting
        repeat (300) @(negedge clk_in);
        exp_cnt = tb_cyc;
        bus_read(32'h30004, b0);
        repeat (7) @(negedge clk_in);
        bus_read(32'h30005, b1);
        bus_read(32'h30006, b2);
        bus_read(32'h30007, b3);
        check_eq("snap2_b0", b0, exp_cnt[7:0]);
        check_eq("snap2_whole", {b3, b2, b1, b0}, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
